// File: rtl/gps_frame_deframer.sv
// Serial measurement deframer: hunts for the sync byte, gathers an 8-byte big-endian
// position/velocity payload, verifies its additive checksum and keeps status counters.
module gps_frame_deframer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hB5,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [31:0]      pos_out,
  output logic [31:0]      vel_out,
  output logic             frame_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] chk_err_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  state_t            state, state_nxt;
  logic [2:0]        idx;
  logic [7:0]        acc;
  logic [TMO_W-1:0]  tmo;
  logic [63:0]       payload;
  logic              frame_ok, chk_bad, tmo_hit, tmo_expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The cycle that would push the idle count to the limit aborts; a valid byte clears it instead.
  assign tmo_expire = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    chk_bad   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid && byte_in == SYNC_BYTE) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (byte_valid) begin
          if (idx == 3'd7) state_nxt = CHECK;
        end else if (tmo_expire) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (byte_valid) begin
          state_nxt = IDLE;
          if (byte_in == acc) frame_ok = 1'b1;
          else                chk_bad  = 1'b1;
        end else if (tmo_expire) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      acc         <= 8'd0;
      tmo         <= '0;
      payload     <= 64'd0;
      pos_out     <= 32'd0;
      vel_out     <= 32'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      chk_err_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      frame_valid <= frame_ok;

      if (state == IDLE) begin
        if (byte_valid && byte_in == SYNC_BYTE) begin
          idx <= 3'd0;
          acc <= 8'd0;
          tmo <= '0;
        end
      end else begin
        tmo <= byte_valid ? '0 : tmo + TMO_W'(1);
        if (state == PAYLOAD && byte_valid) begin
          payload <= {payload[55:0], byte_in};
          acc     <= acc + byte_in;
          idx     <= idx + 3'd1;
        end
      end

      if (frame_ok) begin
        pos_out   <= payload[63:32];
        vel_out   <= payload[31:0];
        frame_cnt <= sat_inc(frame_cnt);
      end
      if (chk_bad) chk_err_cnt <= sat_inc(chk_err_cnt);
      if (tmo_hit) timeout_cnt <= sat_inc(timeout_cnt);
    end
  end

endmodule

// File: doc/gps_frame_deframer.md
Name: gps_frame_deframer

Overview:
- Upstream stage of the navigation processor: converts the receiver's serial measurement byte stream into 32-bit position and velocity words.
- Hunts for a sync byte, collects an 8-byte big-endian payload (position, then velocity) and verifies an 8-bit additive checksum.
- Validated frames are presented as registered pos_out/vel_out with a one-cycle frame_valid strobe, which drive pos_in/vel_in of the navigation processor.
- Counts checksum failures and inter-byte timeouts for status readback.

Parameters:
SYNC_BYTE, 8'hB5, frame start marker.
TIMEOUT_CYCLES, 1024, max idle cycles between bytes inside a frame before abort (>=2).
CNT_W, 16, width of the status counters.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  reset; synchronous to clk, active-high.
byte_in  input  8  receiver data byte.
byte_valid  input  1  byte_in is valid this cycle; no backpressure, every valid byte is consumed.
pos_out  output  32  position of last good frame.
vel_out  output  32  velocity of last good frame.
frame_valid  output  1  one-cycle pulse when pos_out/vel_out update.
busy  output  1  high while in PAYLOAD or CHECK.
frame_cnt  output  CNT_W  good frames received, saturating.
chk_err_cnt  output  CNT_W  checksum failures, saturating.
timeout_cnt  output  CNT_W  timeout aborts, saturating.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, byte index 0, checksum accumulator 0, timeout counter 0, shift register 0.
- FSM states:
  - IDLE: valid byte == SYNC_BYTE -> PAYLOAD, clear index, accumulator and timeout counter. Any other valid byte is discarded.
  - PAYLOAD: each valid byte shifts into a 64-bit register MSB-first and adds into the 8-bit accumulator (mod 256); index increments. On the 8th byte (index 7) -> CHECK.
  - CHECK: the next valid byte is the checksum.
    - Equal to the accumulator: load pos_out = payload[63:32] and vel_out = payload[31:0]; frame_valid = 1 for exactly one cycle (the cycle after the checksum byte is sampled); frame_cnt += 1.
    - Mismatch: pos_out/vel_out hold their values, frame_valid stays 0, chk_err_cnt += 1.
    - Either case -> IDLE.
- Latency: outputs and strobe register on the clock edge that samples the checksum byte; visible in the following cycle.
- A SYNC_BYTE value inside PAYLOAD or CHECK is treated as data or checksum. There is no mid-frame resynchronisation.
- Timeout:
  - In PAYLOAD/CHECK, the timeout counter increments every cycle with byte_valid = 0 and clears on every valid byte.
  - When it reaches TIMEOUT_CYCLES -> IDLE, timeout_cnt += 1, outputs unchanged.
  - If a valid byte arrives in the same cycle as the limit is reached, the byte wins and no timeout occurs.
  - No timeout in IDLE.
- Counters saturate at all-ones and never wrap.
- busy = 1 in PAYLOAD or CHECK, registered with the state.
- Back-to-back frames: a sync byte in the cycle immediately after the checksum byte is accepted (IDLE is reached in one cycle).
- Reset asserted mid-frame: partial frame discarded; all outputs and counters return to 0 on the next edge.

Test Plan:
- Good frame at one byte per cycle: B5 00 00 10 00 FF FF FF F6 03 -> one frame_valid pulse, pos_out = 32'h00001000, vel_out = 32'hFFFFFFF6, frame_cnt = 1, error counters 0.
- Same frame with checksum 04 -> no frame_valid, pos_out/vel_out unchanged from the prior state, chk_err_cnt = 1. The next correct frame is accepted normally.
- Garbage 12 34 B4 before the good frame, and B5 used as a payload byte (B5 00 00 00 B5 00 00 00 01 checksum B6) -> garbage ignored; pos_out = 32'h000000B5, vel_out = 32'h00000001.
- Stall with TIMEOUT_CYCLES = 16:
  - After 3 payload bytes, byte_valid held low 16 cycles -> timeout_cnt = 1, state IDLE, busy = 0.
  - A stall of 15 cycles followed by the remaining bytes -> frame accepted.
- Reset asserted after 5 payload bytes, then a full good frame sent -> all outputs 0 after reset; the new frame decodes correctly with frame_cnt = 1.
- Saturation with CNT_W = 2: 5 bad-checksum frames -> chk_err_cnt = 3.
